// File: rtl/register_bank.sv
// 16x WIDTH register bank fed by a one-hot write decoder; reg 0 reads as zero.
// Reads return 1 cycle after re, with optional same-edge write bypass; no backpressure.
module register_bank #(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [3:0]       ra_a,
    input  logic [3:0]       ra_b,
    output logic [WIDTH-1:0] rd_a,
    output logic [WIDTH-1:0] rd_b,
    output logic             rd_valid,
    output logic             wsel_err
);

    logic [WIDTH-1:0] regs [16];
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic             multi_hot;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hot = |(wsel & (wsel - 16'd1));

    always_comb begin
        next_a = regs[ra_a];
        if (ra_a == 4'd0) begin
            next_a = '0;
        end else if (BYPASS && wsel[ra_a]) begin
            next_a = wdata;
        end
    end

    always_comb begin
        next_b = regs[ra_b];
        if (ra_b == 4'd0) begin
            next_b = '0;
        end else if (BYPASS && wsel[ra_b]) begin
            next_b = wdata;
        end
    end

    // regs[0] is only ever cleared, so it stays a constant zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 16; i++) begin
                if (wsel[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a     <= '0;
            rd_b     <= '0;
            rd_valid <= 1'b0;
            wsel_err <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) begin
                rd_a <= next_a;
                rd_b <= next_b;
            end
            if (multi_hot) begin
                wsel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed scenarios plus random traffic against an array model.
module tb_register_bank;
    localparam int WIDTH  = 32;
    localparam bit BYPASS = 1'b1;

    logic             clk;
    logic             rst_n;
    logic [15:0]      wsel;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [3:0]       ra_a;
    logic [3:0]       ra_b;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             rd_valid;
    logic             wsel_err;

    register_bank #(.WIDTH(WIDTH), .BYPASS(BYPASS)) dut (
        .clk(clk), .rst_n(rst_n), .wsel(wsel), .wdata(wdata), .re(re),
        .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a), .rd_b(rd_b),
        .rd_valid(rd_valid), .wsel_err(wsel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: plain storage array plus expected output values.
    logic [WIDTH-1:0] mem [16];
    logic [WIDTH-1:0] exp_a, exp_b;
    logic             exp_valid, exp_err;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_read(input logic [3:0] a, input logic [15:0] ws,
                                                    input logic [WIDTH-1:0] wd);
        if (a == 4'd0) return '0;
        if (BYPASS && ws[a]) return wd;
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        exp_a = '0; exp_b = '0; exp_valid = 1'b0; exp_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, exp_valid});
        check({tag, ".rd_a"}, rd_a, exp_a);
        check({tag, ".rd_b"}, rd_b, exp_b);
        check({tag, ".wsel_err"}, {31'd0, wsel_err}, {31'd0, exp_err});
    endtask

    // One clock: drive, advance the model by the spec rules, check just after the edge.
    task automatic cycle(input string tag, input logic [15:0] ws, input logic [WIDTH-1:0] wd,
                         input logic r, input logic [3:0] a, input logic [3:0] b);
        wsel = ws; wdata = wd; re = r; ra_a = a; ra_b = b;
        @(posedge clk);
        exp_valid = r;
        if (r) begin
            exp_a = model_read(a, ws, wd);
            exp_b = model_read(b, ws, wd);
        end
        if ($countones(ws) > 1) exp_err = 1'b1;
        for (int i = 1; i < 16; i++) if (ws[i]) mem[i] = wd;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [15:0] rws;
        logic [WIDTH-1:0] rwd;
        int k;

        rst_n = 1'b0; wsel = '0; wdata = '0; re = 1'b0; ra_a = '0; ra_b = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk) rst_n = 1'b1;

        // Reset then read
        cycle("rst_read", 16'h0000, '0, 1'b1, 4'd5, 4'd15);
        check("rst_read.const_a", rd_a, 32'h0);
        cycle("idle0", 16'h0000, '0, 1'b0, 4'd0, 4'd0);

        // Write then read, valid for exactly one cycle
        cycle("wr3", 16'h0008, 32'hDEADBEEF, 1'b0, 4'd0, 4'd0);
        cycle("rd3", 16'h0000, '0, 1'b1, 4'd3, 4'd0);
        check("rd3.const_a", rd_a, 32'hDEADBEEF);
        cycle("rd3_after", 16'h0000, '0, 1'b0, 4'd0, 4'd0);
        check("rd3_after.hold_a", rd_a, 32'hDEADBEEF);

        // Register 0 immunity
        cycle("wr0", 16'h0001, 32'hFFFFFFFF, 1'b0, 4'd0, 4'd0);
        cycle("rd0", 16'h0000, '0, 1'b1, 4'd0, 4'd0);
        check("rd0.const_a", rd_a, 32'h0);

        // Same-edge bypass on both ports
        cycle("wr7", 16'h0080, 32'h11111111, 1'b0, 4'd0, 4'd0);
        cycle("byp7", 16'h0080, 32'h22222222, 1'b1, 4'd7, 4'd7);
        check("byp7.const_a", rd_a, BYPASS ? 32'h22222222 : 32'h11111111);
        check("byp7.const_b", rd_b, BYPASS ? 32'h22222222 : 32'h11111111);
        cycle("rd7", 16'h0000, '0, 1'b1, 4'd7, 4'd3);
        check("rd7.const_a", rd_a, 32'h22222222);

        // Multi-hot write, sticky error
        cycle("multi", 16'h0006, 32'hA5A5A5A5, 1'b0, 4'd0, 4'd0);
        cycle("rd12", 16'h0000, '0, 1'b1, 4'd1, 4'd2);
        check("rd12.const_b", rd_b, 32'hA5A5A5A5);
        cycle("wr4", 16'h0010, 32'h44444444, 1'b0, 4'd0, 4'd0);
        check("sticky_err", {31'd0, wsel_err}, 32'd1);

        // Sweep writes then back-to-back paired reads
        for (int i = 1; i < 16; i++)
            cycle("sweep_wr", 16'(1 << i), WIDTH'(i) * 32'h01010101, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            cycle("sweep_rd", 16'h0000, '0, 1'b1, 4'(i), 4'(15 - i));
            check("sweep_rd.const_a", rd_a, WIDTH'(i) * 32'h01010101);
        end

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            if (k < 3) rws = 16'h0000;
            else if (k < 9) rws = 16'(1 << $urandom_range(0, 15));
            else rws = 16'($urandom);
            rwd = $urandom;
            cycle("rand", rws, rwd, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Reset mid-operation drops the in-flight result asynchronously
        cycle("pre_rst", 16'h0000, '0, 1'b1, 4'd7, 4'd9);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 16; i++)
            cycle("post_rst", 16'h0000, '0, 1'b1, 4'(i), 4'($urandom_range(0, 15)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- 16-entry register array that sits directly downstream of the write-address binary decoder.
- Takes the decoder's 16-bit one-hot write-select vector plus write data and stores the data into the selected register(s).
- Provides two registered read ports with write-to-read bypass.
- Register 0 is hardwired to zero, matching the decoder's convention that address 0 produces an all-zero select.

Parameters:
- WIDTH, 32, data width of each register and of both read ports.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a read of the same register; 0 = the read returns the pre-write contents.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wsel  input  16  one-hot write select (decoder output); bit i selects register i.
- wdata  input  WIDTH  write data.
- re  input  1  read request; both ports are sampled together.
- ra_a  input  4  read address, port A.
- ra_b  input  4  read address, port B.
- rd_a  output  WIDTH  registered read data, port A.
- rd_b  output  WIDTH  registered read data, port B.
- rd_valid  output  1  high for one cycle when rd_a/rd_b hold data for a read accepted on the previous cycle.
- wsel_err  output  1  sticky flag: set when wsel had more than one bit set.

Behaviour:
- Reset, asynchronous on rst_n low: all 16 registers, rd_a, rd_b, rd_valid and wsel_err go to 0 immediately. The block stays in reset until the first rising clk edge after rst_n goes high.
- Write:
  - On a rising clk edge, every register i with wsel[i]=1 and i!=0 loads wdata.
  - wsel[0] is ignored, so register 0 always reads 0.
  - wsel = 0 means no write. This is the normal idle value, since the decoder outputs 0 for address 0 or when it holds.
- Multi-hot wsel (two or more bits set):
  - All selected registers i!=0 are written with the same wdata.
  - wsel_err is set on that edge and stays high until reset. It is not cleared by later valid writes.
- Read:
  - When re=1 at a rising edge, rd_a/rd_b capture the contents of ra_a/ra_b and rd_valid=1 on the following cycle. Latency is exactly 1 cycle.
  - When re=0, rd_a/rd_b hold their previous values and rd_valid=0 that cycle.
  - Back-to-back reads with re held high give one result per cycle.
- Read of address 0 returns 0 regardless of wsel or bypass.
- Bypass (BYPASS=1): if re=1 and wsel[ra_x]=1 (ra_x!=0) on the same edge, rd_x captures wdata, not the old contents. Ports A and B are bypassed independently. If ra_a==ra_b, both ports return identical data.
- Bypass off (BYPASS=0): a same-edge read returns the old value. The new value is visible from the next read onward.
- Register contents are never altered by reads.
- Reset asserted mid-operation:
  - Any in-flight read result is lost: rd_valid drops to 0 asynchronously.
  - Any write on the same edge as reset deassertion is not guaranteed.
  - Registers read 0 after reset.
- Arithmetic/width: no arithmetic. Data is stored and returned bit-exact at WIDTH bits.
- No combinational path from any input to any output. All outputs come from flops.

Test Plan:
- Reset then read: assert rst_n=0 mid-cycle, release, read ra_a=5, ra_b=15 -> rd_valid=1 one cycle later, rd_a=0, rd_b=0, wsel_err=0.
- Write then read: wsel=16'h0008, wdata=32'hDEADBEEF, next cycle re=1 ra_a=3 ra_b=0 -> rd_a=32'hDEADBEEF, rd_b=0, rd_valid high exactly one cycle.
- Register 0 immunity: wsel=16'h0001, wdata=32'hFFFFFFFF, then read ra_a=0 -> rd_a=0.
- Same-cycle bypass: register 7 holds 32'h11111111; on one edge wsel=16'h0080, wdata=32'h22222222, re=1, ra_a=7, ra_b=7 -> BYPASS=1: rd_a=rd_b=32'h22222222; BYPASS=0: rd_a=rd_b=32'h11111111, and the next read returns 32'h22222222.
- Multi-hot write: wsel=16'h0006, wdata=32'hA5A5A5A5 -> registers 1 and 2 both read 32'hA5A5A5A5, wsel_err=1 and stays 1 after a subsequent wsel=16'h0010 write.
- Sweep: drive wsel=1<<i with wdata=i*32'h01010101 for i=1..15 on consecutive cycles, then read all pairs (i, 15-i) with re held high -> each result matches its expected value at 1-cycle latency, with rd_valid continuous.
